// File: rtl/picomips_host_if.sv
// Host-side bundle for the picoMips driver: input pair handshake, switch/LED lines and result handshake.
// The master modport is the environment (stimulus, processor LED, result consumer); slave is the driver.
interface picomips_host_if;
    logic              InValid;
    logic              InReady;
    logic signed [7:0] InX;
    logic signed [7:0] InY;
    logic signed [7:0] SwData;
    logic              SwStrobe;
    logic signed [7:0] Led;
    logic              ResValid;
    logic              ResReady;
    logic signed [7:0] ResX;
    logic signed [7:0] ResY;
    logic              Busy;

    modport master (
        output InValid, InX, InY, Led, ResReady,
        input  InReady, SwData, SwStrobe, ResValid, ResX, ResY, Busy
    );

    modport slave (
        input  InValid, InX, InY, Led, ResReady,
        output InReady, SwData, SwStrobe, ResValid, ResX, ResY, Busy
    );
endinterface

// File: rtl/picomips_host.sv
// Drives the picoMips SW[8] handshake: presents x then y on SW[7:0], strobes SW[8] with a fixed
// hold per phase, captures the two LED outputs and returns them as a result pair.
module picomips_host #(
    parameter int HOLD = 48,
    parameter int CW   = 8
) (
    input logic           Clock,
    input logic           nReset,
    picomips_host_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for an input pair (and for any pending result to be taken)
    // X_HI  | x on SwData, strobe high: processor loads x
    // X_LO  | strobe low
    // Y_HI  | y on SwData, strobe high: processor loads y
    // Y_LO  | strobe low; x2 appears on LED
    // R_HI  | strobe high; y2 appears on LED
    // R_LO  | strobe low; processor settles back to its initial wait
    typedef enum logic [2:0] {IDLE, X_HI, X_LO, Y_HI, Y_LO, R_HI, R_LO} state_t;

    localparam logic [CW-1:0] LOAD = CW'(HOLD - 1);

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     cnt;
    logic              cnt_zero;
    logic              armed;
    logic              accept;
    logic signed [7:0] y_lat;

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)   state_nx = X_HI;
            X_HI:    if (cnt_zero) state_nx = X_LO;
            X_LO:    if (cnt_zero) state_nx = Y_HI;
            Y_HI:    if (cnt_zero) state_nx = Y_LO;
            Y_LO:    if (cnt_zero) state_nx = R_HI;
            R_HI:    if (cnt_zero) state_nx = R_LO;
            R_LO:    if (cnt_zero) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // armed keeps InReady low while reset is held and for the first edge after release
    always_comb begin
        bus.InReady  = armed && (state == IDLE) && !bus.ResValid;
        accept       = bus.InValid && bus.InReady;
        bus.SwStrobe = (state == X_HI) || (state == Y_HI) || (state == R_HI);
        bus.Busy     = (state != IDLE);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cnt <= '0;
        end else if (state_nx != state) begin
            cnt <= (state_nx == IDLE) ? '0 : LOAD;
        end else if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            armed        <= 1'b0;
            y_lat        <= '0;
            bus.SwData   <= '0;
            bus.ResX     <= '0;
            bus.ResY     <= '0;
            bus.ResValid <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                y_lat      <= bus.InY;
                bus.SwData <= bus.InX;
            end
            if (state == X_LO && cnt_zero) bus.SwData <= y_lat;
            if (state == Y_LO && cnt_zero) bus.ResX <= bus.Led;
            if (state == R_HI && cnt_zero) bus.ResY <= bus.Led;
            if (state == R_LO && cnt_zero)
                bus.ResValid <= 1'b1;
            else if (bus.ResValid && bus.ResReady)
                bus.ResValid <= 1'b0;
        end
    end
endmodule
